commit_trace_fifo: RTL and testbench
====================================

Name: commit_trace_fifo

Overview:
- Synthesizable successor to the simulation-only pc/instr trace logger for the multi-cycle MIPS CPU.
- Detects instruction-boundary events on the CPU's architectural PC. Tags each event with the register-file writeback retired since the previous event and a sequence number.
- Buffers records in a parametrised FIFO and streams them out over a valid/ready handshake. Overflow policy is selectable: drop newest or overwrite oldest.
- Sits beside sccpu inside sccomp_dataflow and feeds a UART/debug drain or a bench scoreboard.

Parameters:
- DEPTH, 16, FIFO entries; power of 2, ≥2.
- ADDR_W, 32, PC and instruction width.
- DATA_W, 32, writeback data width.
- SEQ_W, 16, sequence counter width; wraps modulo 2^SEQ_W.
- OVERWRITE, 0, overflow policy: 0 = drop newest record, 1 = discard oldest record.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- capture_en  in  1  enables event detection; while low, no records are pushed, no seq/drop changes, and writeback accumulation still runs.
- flush  in  1  synchronous clear of FIFO contents and drop_cnt.
- pc  in  ADDR_W  current architectural PC.
- inst  in  ADDR_W  current instruction word.
- gr_we  in  1  register-file write strobe (GR_in).
- gr_waddr  in  5  register-file write address.
- gr_wdata  in  DATA_W  register-file write data.
- out_valid  out  1  head record is available.
- out_ready  in  1  consumer accepts the head record.
- out_seq  out  SEQ_W  record sequence number.
- out_pc  out  ADDR_W  record PC.
- out_inst  out  ADDR_W  record instruction.
- out_wb_valid  out  1  a writeback is attached to the record.
- out_wb_addr  out  5  writeback register.
- out_wb_data  out  DATA_W  writeback value.
- level  out  $clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  16  saturating count of lost records.
- full  out  1  level == DEPTH.

Behaviour:
- Reset (asynchronous) values:
  - All outputs 0; level 0.
  - FIFO pointers 0; seq 0; wb accumulator empty.
  - first flag 1; pc_prev 0.
- Event definition: event = capture_en & (first | pc != pc_prev).
  - On an event: pc_prev <= pc; first <= 0.
  - pc_prev updates only on events, so toggling capture_en low never manufactures events.
- Record content:
  - {seq, pc, inst} sampled in the event cycle.
  - Writeback fields come from the accumulator as it stood before this cycle, i.e. writes that completed during the prior instruction.
  - seq increments on every event, including dropped ones, so consumers can see gaps.
- Writeback accumulator:
  - gr_we & gr_waddr != 0 loads {1, addr, data}.
  - Writes to $0 are ignored.
  - A later write before the next event overwrites the earlier one (last write wins).
  - On an event the accumulator clears, unless gr_we is valid in the same cycle; that write loads the fresh accumulator and belongs to the next record.
- FIFO is show-ahead: out_* reflect the head entry combinationally from the pointer; out_* hold stable while out_valid & !out_ready.
- Latency: a record pushed in cycle N is visible on out_valid in cycle N+1.
- Pop when out_valid & out_ready. Pointers are log2(DEPTH)+1 bits with a wrap bit; full and empty are derived from the pointer compare.
- Full with an event:
  - With a simultaneous pop: push succeeds and level is unchanged, regardless of OVERWRITE.
  - OVERWRITE=0, no pop: record discarded; drop_cnt++.
  - OVERWRITE=1, no pop: oldest entry discarded (rd_ptr advances), new record written; drop_cnt++; level stays DEPTH.
- drop_cnt saturates at 16'hFFFF.
- Empty with out_ready: no effect. There is no bypass; a record is never visible in its push cycle.
- flush: pointers, level and drop_cnt clear. An event in the same cycle is discarded; seq still increments. first, pc_prev and the accumulator are unaffected.
- Reset mid-stream: all state is lost immediately; the first PC after reset release produces seq 0.

Decomposition:
- Shared package trace_pkg:
  - trace_rec_t packed struct {seq, pc, inst, wb_valid, wb_addr, wb_data}.
  - Width localparams.
  - DROP_W = 16.
- One sub-module, trace_fifo_mem: parametrised storage array (DEPTH × record width) with registered write and asynchronous read, so it maps to distributed RAM.
- Event detect, accumulator, pointers and policy logic stay in the top.

Test Plan:
- Basic capture: after reset, pc=00400000/inst=08100004, then 00400004 with gr_we to $8 = 5, then 00400008; out_ready=1 throughout -> records seq0 (no wb), seq1 (no wb), seq2 (wb $8 = 00000005), each one cycle after its event.
- Dwell and $0: pc held for 4 cycles with gr_we to $0 and $9 = 7, then $9 = 9 -> exactly one new record, wb $9 = 00000009; the $0 write is never reported.
- Full, drop policy: OVERWRITE=0, DEPTH=4, out_ready=0, 6 PC changes -> level=4, drop_cnt=2, drained seqs 0,1,2,3.
- Full, overwrite policy: OVERWRITE=1, same stimulus -> drop_cnt=2, drained seqs 2,3,4,5.
- Simultaneous push and pop at full plus backpressure: out_ready pulses in the push cycle -> no drop, level stays 4; with out_ready=0, out_* stay constant for 10 cycles.
- Flush and reset: flush coincident with an event -> level=0, drop_cnt=0, next record seq advanced by 2. Reset asserted mid-drain -> out_valid=0 asynchronously; the first record after release is seq0.

Source files
------------

// File: rtl/trace_pkg.sv
// Shared types and widths for the commit trace FIFO: record layout and fixed field widths.
package trace_pkg;

   localparam int TRACE_ADDR_W = 32;
   localparam int TRACE_DATA_W = 32;
   localparam int TRACE_SEQ_W  = 16;
   localparam int WB_ADDR_W    = 5;
   localparam int DROP_W       = 16;

   typedef struct packed {
      logic [TRACE_SEQ_W-1:0]  seq;
      logic [TRACE_ADDR_W-1:0] pc;
      logic [TRACE_ADDR_W-1:0] inst;
      logic                    wb_valid;
      logic [WB_ADDR_W-1:0]    wb_addr;
      logic [TRACE_DATA_W-1:0] wb_data;
   } trace_rec_t;

endpackage

// File: rtl/commit_trace_fifo_if.sv
// Trace record stream: valid/ready handshake carrying the head record of the FIFO.
interface commit_trace_fifo_if
   import trace_pkg::*;
#(
   parameter int ADDR_W = TRACE_ADDR_W,
   parameter int DATA_W = TRACE_DATA_W,
   parameter int SEQ_W  = TRACE_SEQ_W
);

   logic                 out_valid;
   logic                 out_ready;
   logic [SEQ_W-1:0]     out_seq;
   logic [ADDR_W-1:0]    out_pc;
   logic [ADDR_W-1:0]    out_inst;
   logic                 out_wb_valid;
   logic [WB_ADDR_W-1:0] out_wb_addr;
   logic [DATA_W-1:0]    out_wb_data;

   modport master (
      output out_valid, out_seq, out_pc, out_inst, out_wb_valid, out_wb_addr, out_wb_data,
      input  out_ready
   );

   modport slave (
      input  out_valid, out_seq, out_pc, out_inst, out_wb_valid, out_wb_addr, out_wb_data,
      output out_ready
   );

endinterface

// File: rtl/trace_fifo_mem.sv
// Record storage: registered write, asynchronous read, so it maps onto distributed RAM.
module trace_fifo_mem #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [WIDTH-1:0]         wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [WIDTH-1:0]         rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/commit_trace_fifo.sv
// Instruction-boundary trace capture for the multi-cycle CPU: detects PC changes, tags each
// with the writeback retired since the previous boundary, and buffers records for a drain.
module commit_trace_fifo
   import trace_pkg::*;
#(
   parameter int DEPTH     = 16,
   parameter int ADDR_W    = TRACE_ADDR_W,
   parameter int DATA_W    = TRACE_DATA_W,
   parameter int SEQ_W     = TRACE_SEQ_W,
   parameter int OVERWRITE = 0
) (
   input  logic                       clk_in,
   input  logic                       reset,
   input  logic                       capture_en,
   input  logic                       flush,
   input  logic [ADDR_W-1:0]          pc,
   input  logic [ADDR_W-1:0]          inst,
   input  logic                       gr_we,
   input  logic [WB_ADDR_W-1:0]       gr_waddr,
   input  logic [DATA_W-1:0]          gr_wdata,
   commit_trace_fifo_if.master        trace,
   output logic [$clog2(DEPTH):0]     level,
   output logic [DROP_W-1:0]          drop_cnt,
   output logic                       full
);

   localparam int   AW = $clog2(DEPTH);
   localparam logic OW = (OVERWRITE != 0);

   typedef struct packed {
      logic [SEQ_W-1:0]     seq;
      logic [ADDR_W-1:0]    pc;
      logic [ADDR_W-1:0]    inst;
      logic                 wb_valid;
      logic [WB_ADDR_W-1:0] wb_addr;
      logic [DATA_W-1:0]    wb_data;
   } rec_t;

   localparam int REC_W = $bits(rec_t);

   function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] c);
      return (&c) ? c : c + 1'b1;
   endfunction

   logic                 first;
   logic [ADDR_W-1:0]    pc_prev;
   logic [SEQ_W-1:0]     seq;
   logic                 acc_vld;
   logic [WB_ADDR_W-1:0] acc_addr;
   logic [DATA_W-1:0]    acc_data;
   logic                 acc_ld;
   logic                 vld_p0;
   rec_t                 rec_p0;
   logic [AW:0]          wr_ptr;
   logic [AW:0]          rd_ptr;
   logic                 empty;
   logic                 pop;
   logic                 wr_en;
   logic                 drop;
   logic                 rd_adv;
   logic [REC_W-1:0]     rd_data;
   rec_t                 head_p1;

   // Stage p0: event detection and record assembly in the boundary cycle
   always_comb begin
      vld_p0 = capture_en & (first | (pc != pc_prev));
      acc_ld = gr_we & (gr_waddr != '0);
      rec_p0 = '{seq: seq, pc: pc, inst: inst,
                 wb_valid: acc_vld, wb_addr: acc_addr, wb_data: acc_data};
   end

   always_comb begin
      empty  = (wr_ptr == rd_ptr);
      full   = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) & (wr_ptr[AW] != rd_ptr[AW]);
      level  = wr_ptr - rd_ptr;
      pop    = ~empty & trace.out_ready;
      // A pop in the same cycle frees the slot, so only an unpopped full FIFO loses a record
      wr_en  = vld_p0 & ~flush & (~full | pop | OW);
      drop   = vld_p0 & ~flush & full & ~pop;
      rd_adv = pop | (drop & OW);
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         first    <= 1'b1;
         pc_prev  <= '0;
         seq      <= '0;
         acc_vld  <= 1'b0;
         acc_addr <= '0;
         acc_data <= '0;
      end else begin
         if (vld_p0) begin
            first   <= 1'b0;
            pc_prev <= pc;
            seq     <= seq + 1'b1;
         end
         // A write in the boundary cycle belongs to the next record
         if (acc_ld) begin
            acc_vld  <= 1'b1;
            acc_addr <= gr_waddr;
            acc_data <= gr_wdata;
         end else if (vld_p0) begin
            acc_vld  <= 1'b0;
            acc_addr <= '0;
            acc_data <= '0;
         end
      end
   end

   always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         drop_cnt <= '0;
      end else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         drop_cnt <= '0;
      end else begin
         if (wr_en)  wr_ptr   <= wr_ptr + 1'b1;
         if (rd_adv) rd_ptr   <= rd_ptr + 1'b1;
         if (drop)   drop_cnt <= sat_inc(drop_cnt);
      end
   end

   trace_fifo_mem #(
      .DEPTH (DEPTH),
      .WIDTH (REC_W)
   ) u_mem (
      .clk   (clk_in),
      .we    (wr_en),
      .waddr (wr_ptr[AW-1:0]),
      .wdata (rec_p0),
      .raddr (rd_ptr[AW-1:0]),
      .rdata (rd_data)
   );

   // Stage p1: show-ahead head, forced to zero while empty
   always_comb head_p1 = empty ? '0 : rec_t'(rd_data);

   assign trace.out_valid    = ~empty;
   assign trace.out_seq      = head_p1.seq;
   assign trace.out_pc       = head_p1.pc;
   assign trace.out_inst     = head_p1.inst;
   assign trace.out_wb_valid = head_p1.wb_valid;
   assign trace.out_wb_addr  = head_p1.wb_addr;
   assign trace.out_wb_data  = head_p1.wb_data;

endmodule

// File: tb/tb_commit_trace_fifo.sv
// Bench for commit_trace_fifo: drop-newest and overwrite-oldest instances share one stimulus
// and are checked every cycle against a queue model, plus hand-computed literal expectations.
module tb_commit_trace_fifo;
   import trace_pkg::*;

   localparam int DEPTH = 4;
   localparam int LVL_W = $clog2(DEPTH) + 1;

   logic        clk_in = 1'b0;
   logic        reset = 1'b1;
   logic        capture_en = 1'b0;
   logic        flush = 1'b0;
   logic [31:0] pc = '0;
   logic [31:0] inst = '0;
   logic        gr_we = 1'b0;
   logic [4:0]  gr_waddr = '0;
   logic [31:0] gr_wdata = '0;
   logic        out_ready = 1'b0;

   logic [LVL_W-1:0] level0, level1;
   logic [15:0]      drop0, drop1;
   logic             full0, full1;

   int n_checks = 0;
   int n_fail = 0;

   commit_trace_fifo_if #(.ADDR_W(32), .DATA_W(32), .SEQ_W(16)) if0 ();
   commit_trace_fifo_if #(.ADDR_W(32), .DATA_W(32), .SEQ_W(16)) if1 ();
   assign if0.out_ready = out_ready;
   assign if1.out_ready = out_ready;

   commit_trace_fifo #(.DEPTH(DEPTH), .OVERWRITE(0)) dut0 (
      .clk_in(clk_in), .reset(reset), .capture_en(capture_en), .flush(flush),
      .pc(pc), .inst(inst), .gr_we(gr_we), .gr_waddr(gr_waddr), .gr_wdata(gr_wdata),
      .trace(if0), .level(level0), .drop_cnt(drop0), .full(full0)
   );

   commit_trace_fifo #(.DEPTH(DEPTH), .OVERWRITE(1)) dut1 (
      .clk_in(clk_in), .reset(reset), .capture_en(capture_en), .flush(flush),
      .pc(pc), .inst(inst), .gr_we(gr_we), .gr_waddr(gr_waddr), .gr_wdata(gr_wdata),
      .trace(if1), .level(level1), .drop_cnt(drop1), .full(full1)
   );

   always #5 clk_in = ~clk_in;

   trace_rec_t h0, h1;
   assign h0 = {if0.out_seq, if0.out_pc, if0.out_inst, if0.out_wb_valid, if0.out_wb_addr, if0.out_wb_data};
   assign h1 = {if1.out_seq, if1.out_pc, if1.out_inst, if1.out_wb_valid, if1.out_wb_addr, if1.out_wb_data};

   task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
      end
   endtask

   // Model state: one event/accumulator tracker, one queue and drop count per policy
   trace_rec_t  mq0[$], mq1[$], log0[$], log1[$];
   logic [15:0] md0, md1, m_seq;
   logic        m_first, m_acc_v;
   logic [31:0] m_pc_prev, m_acc_d;
   logic [4:0]  m_acc_a;

   task automatic model_reset();
      mq0.delete(); mq1.delete();
      md0 = '0; md1 = '0; m_seq = '0;
      m_first = 1'b1; m_pc_prev = '0;
      m_acc_v = 1'b0; m_acc_a = '0; m_acc_d = '0;
   endtask

   always @(negedge clk_in) begin
      trace_rec_t e0, e1, r;
      logic ev;
      if (reset) model_reset();
      e0 = (mq0.size() > 0) ? mq0[0] : '0;
      e1 = (mq1.size() > 0) ? mq1[0] : '0;
      chk("valid0", if0.out_valid, mq0.size() > 0);
      chk("head0", h0, e0);
      chk("level0", level0, mq0.size());
      chk("full0", full0, mq0.size() == DEPTH);
      chk("drop0", drop0, md0);
      chk("valid1", if1.out_valid, mq1.size() > 0);
      chk("head1", h1, e1);
      chk("level1", level1, mq1.size());
      chk("full1", full1, mq1.size() == DEPTH);
      chk("drop1", drop1, md1);
      if (!reset) begin
         if (if0.out_valid && out_ready) log0.push_back(h0);
         if (if1.out_valid && out_ready) log1.push_back(h1);
         ev = capture_en && (m_first || pc != m_pc_prev);
         r = '{seq: m_seq, pc: pc, inst: inst, wb_valid: m_acc_v, wb_addr: m_acc_a, wb_data: m_acc_d};
         if (flush) begin
            mq0.delete(); mq1.delete(); md0 = '0; md1 = '0;
         end else begin
            if (mq0.size() > 0 && out_ready) void'(mq0.pop_front());
            if (mq1.size() > 0 && out_ready) void'(mq1.pop_front());
            if (ev) begin
               if (mq0.size() < DEPTH) mq0.push_back(r);
               else if (md0 != 16'hFFFF) md0++;
               if (mq1.size() < DEPTH) mq1.push_back(r);
               else begin
                  void'(mq1.pop_front());
                  mq1.push_back(r);
                  if (md1 != 16'hFFFF) md1++;
               end
            end
         end
         if (ev) begin
            m_seq++;
            m_first = 1'b0;
            m_pc_prev = pc;
         end
         if (gr_we && gr_waddr != 5'd0) begin
            m_acc_v = 1'b1; m_acc_a = gr_waddr; m_acc_d = gr_wdata;
         end else if (ev) begin
            m_acc_v = 1'b0; m_acc_a = '0; m_acc_d = '0;
         end
      end
   end

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic set_cpu(input logic [31:0] p, input logic [31:0] i, input logic we,
                          input logic [4:0] a, input logic [31:0] d);
      pc = p; inst = i; gr_we = we; gr_waddr = a; gr_wdata = d;
   endtask

   initial begin
      model_reset();
      repeat (3) tick();
      chk("rst_valid", if0.out_valid, 1'b0);
      chk("rst_level", level0, 0);
      chk("rst_drop", drop1, 0);

      // Basic capture with writeback attribution
      reset = 1'b0; capture_en = 1'b1; out_ready = 1'b1;
      set_cpu(32'h00400000, 32'h08100004, 1'b0, 5'd0, 32'h0);
      chk("no_bypass", if0.out_valid, 1'b0);
      tick();
      chk("lat_valid", if0.out_valid, 1'b1);
      chk("lat_seq", if0.out_seq, 16'd0);
      chk("lat_pc", if0.out_pc, 32'h00400000);
      set_cpu(32'h00400004, 32'h24080005, 1'b1, 5'd8, 32'h5);
      tick();
      set_cpu(32'h00400008, 32'h01094820, 1'b0, 5'd0, 32'h0);
      tick();
      // Dwell on one PC with a $0 write and two $9 writes
      set_cpu(32'h0040000C, 32'h24090007, 1'b0, 5'd0, 32'h0);
      tick();
      set_cpu(32'h0040000C, 32'h24090007, 1'b1, 5'd0, 32'hDEADBEEF);
      tick();
      set_cpu(32'h0040000C, 32'h24090007, 1'b1, 5'd9, 32'h7);
      tick();
      set_cpu(32'h0040000C, 32'h24090007, 1'b1, 5'd9, 32'h9);
      tick();
      chk("dwell_count", log0.size(), 4);
      set_cpu(32'h00400010, 32'h00000000, 1'b0, 5'd0, 32'h0);
      tick();
      tick();
      chk("basic_count", log0.size(), 5);
      if (log0.size() == 5) begin
         chk("r0_seq", log0[0].seq, 0);
         chk("r0_wbv", log0[0].wb_valid, 0);
         chk("r1_seq", log0[1].seq, 1);
         chk("r1_wbv", log0[1].wb_valid, 0);
         chk("r2_seq", log0[2].seq, 2);
         chk("r2_pc", log0[2].pc, 32'h00400008);
         chk("r2_wb", {log0[2].wb_valid, log0[2].wb_addr, log0[2].wb_data}, {1'b1, 5'd8, 32'h5});
         chk("r3_wbv", log0[3].wb_valid, 0);
         chk("r4_seq", log0[4].seq, 4);
         chk("r4_wb", {log0[4].wb_valid, log0[4].wb_addr, log0[4].wb_data}, {1'b1, 5'd9, 32'h9});
      end

      // Overflow with no consumer
      reset = 1'b1;
      tick();
      reset = 1'b0; out_ready = 1'b0;
      log0.delete(); log1.delete();
      for (int k = 0; k < 6; k++) begin
         set_cpu(32'h00401000 + 32'(4 * k), 32'h10000000 + 32'(k), 1'b0, 5'd0, 32'h0);
         tick();
      end
      chk("ovf_level0", level0, 4);
      chk("ovf_drop0", drop0, 2);
      chk("ovf_full0", full0, 1'b1);
      chk("ovf_level1", level1, 4);
      chk("ovf_drop1", drop1, 2);
      chk("ovf_head1", if1.out_seq, 2);
      out_ready = 1'b1;
      repeat (4) tick();
      out_ready = 1'b0;
      chk("drain_n0", log0.size(), 4);
      chk("drain_n1", log1.size(), 4);
      for (int k = 0; k < 4 && k < log0.size(); k++) chk("drain_seq0", log0[k].seq, k);
      for (int k = 0; k < 4 && k < log1.size(); k++) chk("drain_seq1", log1[k].seq, k + 2);

      // Refill, then push and pop together at full
      for (int k = 0; k < 4; k++) begin
         set_cpu(32'h00402000 + 32'(4 * k), 32'h20000000 + 32'(k), 1'b0, 5'd0, 32'h0);
         tick();
      end
      set_cpu(32'h00402010, 32'h20000004, 1'b0, 5'd0, 32'h0);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("pp_level0", level0, 4);
      chk("pp_drop0", drop0, 2);
      chk("pp_level1", level1, 4);
      chk("pp_drop1", drop1, 2);
      for (int k = 0; k < 10; k++) begin
         chk("hold_seq0", if0.out_seq, 7);
         chk("hold_pc0", if0.out_pc, 32'h00402004);
         chk("hold_inst1", if1.out_inst, 32'h20000001);
         tick();
      end

      // Flush coincident with an event
      flush = 1'b1;
      set_cpu(32'h00403000, 32'h30000000, 1'b0, 5'd0, 32'h0);
      tick();
      flush = 1'b0;
      chk("fl_level0", level0, 0);
      chk("fl_drop0", drop0, 0);
      chk("fl_valid1", if1.out_valid, 1'b0);
      set_cpu(32'h00403004, 32'h30000001, 1'b0, 5'd0, 32'h0);
      tick();
      chk("fl_seq", if0.out_seq, 12);
      chk("fl_pc", if1.out_pc, 32'h00403004);

      // Reset in the middle of a drain
      set_cpu(32'h00403008, 32'h30000002, 1'b0, 5'd0, 32'h0);
      tick();
      out_ready = 1'b1;
      tick();
      chk("mid_seq", if0.out_seq, 13);
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid0", if0.out_valid, 1'b0);
      chk("arst_level1", level1, 0);
      @(posedge clk_in);
      #1;
      reset = 1'b0;
      set_cpu(32'h00404000, 32'h40000000, 1'b0, 5'd0, 32'h0);
      tick();
      chk("post_valid", if0.out_valid, 1'b1);
      chk("post_seq0", if0.out_seq, 0);
      chk("post_seq1", if1.out_seq, 0);
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
